dev_rw_responder: RTL
=====================

DEV_RW_RESPONDER -- requirements
Module: dev_rw_responder

Interface
REQ-001 Parameter WAIT_LIMIT, default 255: max idle cycles between expected packets before abort.
REQ-002 Parameter MAX_RETRY, default 8: max host NAKs tolerated on one read-data packet.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_L  input  1  reset, asynchronous, active-low.
REQ-005 pkt_valid  input  1  one-cycle pulse: decoded packet from device protocol layer.
REQ-006 pkt_type  input  3  NONE=000, IN_TOK=001, OUT_TOK=010, OUT_DATA=011, HS_ACK=101, HS_NAK=110.
REQ-007 pkt_ok  input  1  CRC/PID check passed; qualifies pkt_valid.
REQ-008 pkt_data  input  64  payload of OUT_DATA packets.
REQ-009 tx_ready  input  1  transmitter idle, can accept tx_start.
REQ-010 tx_start  output  1  one-cycle pulse: send packet of tx_type.
REQ-011 tx_type  output  2  ACK=00, NAK=01, DATA=10.
REQ-012 tx_data  output  64  payload for DATA packets, stable from tx_start until tx_ready returns high.
REQ-013 mem_addr  output  16  page address; mem_we/mem_re  output  1 each; mem_wdata  output  64; mem_rdata  input  64 (valid one cycle after mem_re).
REQ-014 xact_done, xact_abort  output  1 each, one-cycle pulses; xact_write  output  1, valid with xact_done (1=write, 0=read).

Function
REQ-015 States: IDLE, GET_PAGE, ACK_PAGE, NEXT_TOK, RD_FETCH, RD_SEND, RD_WAIT_HS, GET_DATA, ACK_DATA.
REQ-016 Packets with pkt_ok=0 are ignored except in GET_PAGE/GET_DATA, where an OUT_DATA with pkt_ok=0 causes a NAK and no state advance beyond the ACK/NAK state.
REQ-017 IDLE: valid OUT_TOK -> GET_PAGE; all other packets ignored.
REQ-018 GET_PAGE: OUT_DATA -> page register loads pkt_data[15:0] if pkt_ok, -> ACK_PAGE with ACK (ok) or NAK (bad).
REQ-019 ACK_PAGE: wait tx_ready, pulse tx_start with pending handshake; ACK -> NEXT_TOK, NAK -> GET_PAGE.
REQ-020 NEXT_TOK: IN_TOK -> RD_FETCH; OUT_TOK -> GET_DATA.
REQ-021 RD_FETCH: mem_re=1 for one cycle, mem_addr=page; next cycle latch mem_rdata into tx_data register -> RD_SEND.
REQ-022 RD_SEND: wait tx_ready, pulse tx_start, tx_type=DATA -> RD_WAIT_HS.
REQ-023 RD_WAIT_HS: HS_ACK -> IDLE, xact_done=1, xact_write=0; HS_NAK -> increment retry count, -> RD_SEND; NAK when retry count = MAX_RETRY-1 -> IDLE with xact_abort.
REQ-024 GET_DATA: OUT_DATA -> ACK_DATA; if pkt_ok, mem_we=1 same cycle, mem_addr=page, mem_wdata=pkt_data.
REQ-025 ACK_DATA: wait tx_ready, pulse tx_start; ACK -> IDLE with xact_done=1, xact_write=1; NAK -> GET_DATA.
REQ-026 Wait counter: 8-bit, cleared on every state change and every valid packet; increments in GET_PAGE, NEXT_TOK, RD_WAIT_HS, GET_DATA; reaching WAIT_LIMIT -> IDLE, xact_abort=1, retry count cleared.
REQ-027 Wait timeout and a valid packet in the same cycle: packet wins.
REQ-028 Unexpected packet type in a non-IDLE wait state: ignored, counter keeps running; OUT_TOK in NEXT_TOK is legal.
REQ-029 tx_start never asserted while tx_ready=0; at most one tx_start per handshake/data state entry.
REQ-030 Memory write is never issued on a bad-CRC packet; duplicate good OUT_DATA after a lost ACK is not handled (host restarts with OUT_TOK).

Reset
REQ-031 rst_L low: state IDLE, page=0, tx_data=0, retry=0, counter=0; all pulse outputs, mem_we, mem_re, tx_start = 0.
REQ-032 Reset mid-transaction discards the transaction with no xact_done/xact_abort pulse.

Structure
REQ-033 Packet-type and handshake-type encodings, and WAIT_LIMIT/MAX_RETRY defaults, live in the shared USB package used by host-side blocks.
REQ-034 One sub-module: the team's generic load/clear register, instanced for page (16) and tx_data (64).

Verification
REQ-035 Read: OUT_TOK, OUT_DATA 0x0042, IN_TOK, mem_rdata=0xDEADBEEF_CAFEF00D, HS_ACK -> ACK, ACK? no: one ACK, one DATA with that payload, mem_addr=0x0042, xact_done with xact_write=0.
REQ-036 Write: OUT_TOK, OUT_DATA 0x0007, OUT_TOK, OUT_DATA 0x1122334455667788 -> two ACKs, one mem_we at addr 0x0007 with that data, xact_done with xact_write=1.
REQ-037 Bad CRC: page OUT_DATA with pkt_ok=0 then good retry 0x0010 -> NAK then ACK, page=0x0010, no mem_we.
REQ-038 Read retry: 8 consecutive HS_NAK -> 8 DATA packets, then xact_abort, state IDLE.
REQ-039 Timeout: OUT_TOK then silence 255 cycles -> xact_abort exactly at cycle 255, no tx_start.
REQ-040 Reset asserted in RD_WAIT_HS -> outputs zero immediately, no pulses, next OUT_TOK accepted normally.

Source files
------------

// File: rtl/dev_rw_responder_pkg.sv
// Shared USB encodings and default limits for the device read/write responder
// and the host-side blocks that talk to it.
package dev_rw_responder_pkg;

    // Decoded packet types from the protocol layer
    localparam logic [2:0] PKT_NONE     = 3'b000;
    localparam logic [2:0] PKT_IN_TOK   = 3'b001;
    localparam logic [2:0] PKT_OUT_TOK  = 3'b010;
    localparam logic [2:0] PKT_OUT_DATA = 3'b011;
    localparam logic [2:0] PKT_HS_ACK   = 3'b101;
    localparam logic [2:0] PKT_HS_NAK   = 3'b110;

    // Packet kinds handed to the transmitter
    localparam logic [1:0] TX_ACK  = 2'b00;
    localparam logic [1:0] TX_NAK  = 2'b01;
    localparam logic [1:0] TX_DATA = 2'b10;

    // Idle cycles tolerated between packets, and host NAKs per read-data packet
    localparam int WAIT_LIMIT_DEF = 255;
    localparam int MAX_RETRY_DEF  = 8;

endpackage

// File: rtl/dev_rw_responder_ldreg.sv
// Generic load/clear register: clear has priority over load, async reset to zero.
module dev_rw_responder_ldreg
    import dev_rw_responder_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              ld,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Hold value; clear wins over load
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L)   q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= d;
    end

endmodule

// File: rtl/dev_rw_responder.sv
// Device-side responder for a two-phase page/data transaction: the host sends
// a page address, then either reads one 64-bit word (IN) or writes one (OUT).
module dev_rw_responder
    import dev_rw_responder_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        pkt_valid,
    input  logic [2:0]  pkt_type,
    input  logic        pkt_ok,
    input  logic [63:0] pkt_data,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [1:0]  tx_type,
    output logic [63:0] tx_data,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        xact_done,
    output logic        xact_abort,
    output logic        xact_write
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_GET_PAGE   = 4'd1;
    localparam logic [3:0] S_ACK_PAGE   = 4'd2;
    localparam logic [3:0] S_NEXT_TOK   = 4'd3;
    localparam logic [3:0] S_RD_FETCH   = 4'd4;
    localparam logic [3:0] S_RD_SEND    = 4'd5;
    localparam logic [3:0] S_RD_WAIT_HS = 4'd6;
    localparam logic [3:0] S_GET_DATA   = 4'd7;
    localparam logic [3:0] S_ACK_DATA   = 4'd8;

    logic [3:0]  st, st_nxt;
    logic        nak, nak_nxt;          // pending handshake is NAK (bad CRC seen)
    logic        fetch_pend, fetch_nxt; // second cycle of RD_FETCH: rdata is valid
    logic [7:0]  retry, retry_nxt;
    logic [7:0]  wait_cnt;
    logic        done_nxt, abort_nxt, write_nxt;
    logic        pkt_good, pkt_od, wait_st;
    logic        page_ld, txd_ld;
    logic [15:0] page;

    assign pkt_good = pkt_valid && pkt_ok;
    // OUT_DATA is acted on even with a bad check so that it can be NAKed
    assign pkt_od   = pkt_valid && (pkt_type == PKT_OUT_DATA);
    assign wait_st  = (st == S_GET_PAGE) || (st == S_NEXT_TOK) ||
                      (st == S_RD_WAIT_HS) || (st == S_GET_DATA);

    assign page_ld  = (st == S_GET_PAGE) && pkt_od && pkt_ok;
    assign txd_ld   = (st == S_RD_FETCH) && fetch_pend;

    dev_rw_responder_ldreg #(.DATA_W(16)) u_page (
        .clk   (clk),
        .rst_L (rst_L),
        .ld    (page_ld),
        .clr   (1'b0),
        .d     (pkt_data[15:0]),
        .q     (page)
    );

    dev_rw_responder_ldreg #(.DATA_W(64)) u_txd (
        .clk   (clk),
        .rst_L (rst_L),
        .ld    (txd_ld),
        .clr   (1'b0),
        .d     (mem_rdata),
        .q     (tx_data)
    );

    // tx_start is gated by tx_ready directly so it can never fire while busy;
    // the state leaves the send state on the same edge, giving one pulse per entry
    assign tx_start  = tx_ready && ((st == S_ACK_PAGE) || (st == S_ACK_DATA) ||
                                    (st == S_RD_SEND));
    assign tx_type   = (st == S_RD_SEND) ? TX_DATA : (nak ? TX_NAK : TX_ACK);
    assign mem_addr  = page;
    assign mem_wdata = pkt_data;
    assign mem_we    = (st == S_GET_DATA) && pkt_od && pkt_ok;
    assign mem_re    = (st == S_RD_FETCH) && !fetch_pend;

    // Next-state and transaction-result decode
    always_comb begin
        st_nxt    = st;
        nak_nxt   = nak;
        fetch_nxt = fetch_pend;
        retry_nxt = retry;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        write_nxt = 1'b0;
        case (st)
            S_IDLE: begin
                if (pkt_good && pkt_type == PKT_OUT_TOK) st_nxt = S_GET_PAGE;
            end
            S_GET_PAGE: begin
                if (pkt_od) begin
                    st_nxt  = S_ACK_PAGE;
                    nak_nxt = !pkt_ok;
                end
            end
            S_ACK_PAGE: begin
                if (tx_ready) st_nxt = nak ? S_GET_PAGE : S_NEXT_TOK;
            end
            S_NEXT_TOK: begin
                if (pkt_good && pkt_type == PKT_IN_TOK) begin
                    st_nxt    = S_RD_FETCH;
                    retry_nxt = 8'd0;
                end else if (pkt_good && pkt_type == PKT_OUT_TOK) begin
                    st_nxt = S_GET_DATA;
                end
            end
            S_RD_FETCH: begin
                if (!fetch_pend) begin
                    fetch_nxt = 1'b1;
                end else begin
                    fetch_nxt = 1'b0;
                    st_nxt    = S_RD_SEND;
                end
            end
            S_RD_SEND: begin
                if (tx_ready) st_nxt = S_RD_WAIT_HS;
            end
            S_RD_WAIT_HS: begin
                if (pkt_good && pkt_type == PKT_HS_ACK) begin
                    st_nxt    = S_IDLE;
                    done_nxt  = 1'b1;
                    retry_nxt = 8'd0;
                end else if (pkt_good && pkt_type == PKT_HS_NAK) begin
                    if (retry == 8'(MAX_RETRY - 1)) begin
                        st_nxt    = S_IDLE;
                        abort_nxt = 1'b1;
                        retry_nxt = 8'd0;
                    end else begin
                        st_nxt    = S_RD_SEND;
                        retry_nxt = retry + 8'd1;
                    end
                end
            end
            S_GET_DATA: begin
                if (pkt_od) begin
                    st_nxt  = S_ACK_DATA;
                    nak_nxt = !pkt_ok;
                end
            end
            S_ACK_DATA: begin
                if (tx_ready) begin
                    if (nak) begin
                        st_nxt = S_GET_DATA;
                    end else begin
                        st_nxt    = S_IDLE;
                        done_nxt  = 1'b1;
                        write_nxt = 1'b1;
                    end
                end
            end
            default: st_nxt = S_IDLE;
        endcase
        // A packet arriving on the timeout cycle takes precedence
        if (wait_st && (st_nxt == st) && !pkt_good &&
            (wait_cnt == 8'(WAIT_LIMIT - 1))) begin
            st_nxt    = S_IDLE;
            abort_nxt = 1'b1;
            retry_nxt = 8'd0;
        end
    end

    // Control state, wait counter and result pulses
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            st         <= S_IDLE;
            nak        <= 1'b0;
            fetch_pend <= 1'b0;
            retry      <= 8'd0;
            wait_cnt   <= 8'd0;
            xact_done  <= 1'b0;
            xact_abort <= 1'b0;
            xact_write <= 1'b0;
        end else begin
            st         <= st_nxt;
            nak        <= nak_nxt;
            fetch_pend <= fetch_nxt;
            retry      <= retry_nxt;
            xact_done  <= done_nxt;
            xact_abort <= abort_nxt;
            xact_write <= write_nxt;
            if ((st_nxt != st) || pkt_good) wait_cnt <= 8'd0;
            else if (wait_st)               wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule
